// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target (responder) exposing an 8-bit register port.
// SCL/SDA are oversampled in the clock domain (clock >= 16x SCL). SDA is
// open-drain: the pad ties SDA = sda_oe ? 1'b0 : 1'bz. SCL is never driven.
// Optional build macro: I2C_GLITCH_FILTER_EN adds a FILTER_DEPTH-sample
// glitch filter after the synchronizers; without it every transition counts.
//
// Core-side handshake:
//   reg_we    : one-cycle strobe; reg_addr/reg_wdata are valid in that cycle.
//               reg_addr advances by one (8-bit wrap) on the following cycle.
//   reg_re    : one-cycle read request for reg_addr; the core presents
//               reg_rdata during the next cycle, and it is captured at the
//               end of that cycle (one cycle after the reg_re cycle).
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR  = 7'h50,
  parameter int         FILTER_DEPTH = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [2:0] fsm_state
);

`ifdef I2C_GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6
  } state_t;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shifter;
  logic       rw;
  logic       first_byte;
  logic       ack_on;     // ADDR_ACK/WR_ACK: ACK driven; RD_ACK: master ACKed
  logic       rd_load;    // reg_rdata is valid this cycle

  // Two-flop synchronizers; idle bus level is high.
  logic scl_s1, scl_s2, sda_s1, sda_s2;

  // Bring the asynchronous pad inputs into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
    end
  end

  logic scl_f, sda_f;

  generate
    if (FILTER_ON && (FILTER_DEPTH > 1)) begin : g_filter
      logic [7:0] scl_cnt, sda_cnt;
      logic       scl_q, sda_q;

      // A line changes only after FILTER_DEPTH consecutive differing samples.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          scl_q   <= 1'b1;
          sda_q   <= 1'b1;
          scl_cnt <= '0;
          sda_cnt <= '0;
        end else begin
          if (scl_s2 == scl_q) begin
            scl_cnt <= '0;
          end else if (scl_cnt == 8'(FILTER_DEPTH - 1)) begin
            scl_q   <= scl_s2;
            scl_cnt <= '0;
          end else begin
            scl_cnt <= scl_cnt + 8'd1;
          end
          if (sda_s2 == sda_q) begin
            sda_cnt <= '0;
          end else if (sda_cnt == 8'(FILTER_DEPTH - 1)) begin
            sda_q   <= sda_s2;
            sda_cnt <= '0;
          end else begin
            sda_cnt <= sda_cnt + 8'd1;
          end
        end
      end

      assign scl_f = scl_q;
      assign sda_f = sda_q;
    end else begin : g_direct
      assign scl_f = scl_s2;
      assign sda_f = sda_s2;
    end
  endgenerate

  // Previous filtered levels for edge detection.
  logic scl_d, sda_d;

  // Delay the filtered lines by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, bus_start, bus_stop;
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign bus_start = scl_f & scl_d & sda_d & ~sda_f;
  assign bus_stop  = scl_f & scl_d & ~sda_d & sda_f;

  assign fsm_state = state;

  // Protocol FSM: START/STOP override every state; bits are sampled on SCL
  // rising edges and SDA drive changes only after an SCL falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shifter    <= '0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      ack_on     <= 1'b0;
      rd_load    <= 1'b0;
      sda_oe     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      rd_load <= reg_re;
      if (rd_load) shifter <= reg_rdata;
      // Pointer advances the cycle after a write strobe.
      if (reg_we) reg_addr <= reg_addr + 8'd1;

      if (bus_stop) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
      end else if (bus_start) begin
        // Repeated START keeps reg_addr so a pointer write can precede a read.
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            sda_oe <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shifter <= {shifter[6:0], sda_f};
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (shifter[6:0] == TARGET_ADDR) begin
                  state  <= ST_ADDR_ACK;
                  rw     <= sda_f;
                  busy   <= 1'b1;
                  ack_on <= 1'b0;
                end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= '0;
                if (rw) begin
                  sda_oe  <= ~shifter[7];
                  shifter <= {shifter[6:0], 1'b0};
                  state   <= ST_RD_BYTE;
                end else begin
                  sda_oe     <= 1'b0;
                  first_byte <= 1'b1;
                  state      <= ST_WR_BYTE;
                end
              end
            end else if (scl_rise && ack_on && rw) begin
              reg_re <= 1'b1;
            end
          end

          ST_WR_BYTE: begin
            if (scl_rise) begin
              shifter <= {shifter[6:0], sda_f};
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                ack_on  <= 1'b0;
                state   <= ST_WR_ACK;
                if (first_byte) begin
                  reg_addr   <= {shifter[6:0], sda_f};
                  first_byte <= 1'b0;
                end else begin
                  reg_wdata <= {shifter[6:0], sda_f};
                  reg_we    <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ST_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_WR_BYTE;
              end
            end
          end

          ST_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe   <= 1'b0;
                bit_cnt  <= '0;
                reg_addr <= reg_addr + 8'd1;
                state    <= ST_RD_ACK;
              end else begin
                sda_oe  <= ~shifter[7];
                shifter <= {shifter[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                reg_re <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else if (scl_fall && ack_on) begin
              ack_on  <= 1'b0;
              sda_oe  <= ~shifter[7];
              shifter <= {shifter[6:0], 1'b0};
              bit_cnt <= '0;
              state   <= ST_RD_BYTE;
            end
          end

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-level I2C master, a core model that answers
// read requests, and a transaction-level reference model of the register
// pointer. SCL runs at clock/32.
module tb_i2c_target_regs;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl   = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] reg_rdata = 8'h00;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [2:0] fsm_state;
  wire        sda_line = sda_m & ~sda_oe;

  int n_cmp = 0;
  int n_err = 0;
  int oe_cycles = 0;

  logic [15:0] exp_we_q[$];
  logic [15:0] got_we_q[$];
  logic [7:0]  exp_re_q[$];
  logic [7:0]  got_re_q[$];
  logic [7:0]  core_q[$];
  logic [7:0]  sent_q[$];
  logic [7:0]  wr_data_q[$];
  logic [7:0]  m_ptr = 8'h00;

  i2c_target_regs #(.TARGET_ADDR(7'h50), .FILTER_DEPTH(3)) dut (
    .clock(clock), .reset(reset), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Core model and bus monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (reg_we) got_we_q.push_back({reg_addr, reg_wdata});
      if (reg_re) begin
        got_re_q.push_back(reg_addr);
        if (core_q.size() > 0) reg_rdata = core_q.pop_front();
        else reg_rdata = 8'($urandom);
        sent_q.push_back(reg_rdata);
      end
      if (sda_oe) oe_cycles++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_start();
    if (!scl) begin
      sda_m = 1'b1; wait_clk(8);
      scl = 1'b1;   wait_clk(8);
    end
    sda_m = 1'b0; wait_clk(16);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(8); sda_m = 1'b0;
    wait_clk(8); scl = 1'b1;
    wait_clk(8); sda_m = 1'b1;
    wait_clk(16);
  endtask

  // One SCL period; optional one-cycle low glitch in the high phase.
  task automatic clk_bit(input logic b, input bit glitch, output logic s);
    wait_clk(8); sda_m = b;
    wait_clk(8); scl = 1'b1;
    wait_clk(8); s = sda_line;
    if (glitch) begin
      scl = 1'b0; wait_clk(1);
      scl = 1'b1; wait_clk(7);
    end else begin
      wait_clk(8);
    end
    scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_at, output logic ack);
    logic s;
    for (int i = 0; i < 8; i++) clk_bit(d[7-i], (i == glitch_at), s);
    clk_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    clk_bit(nack, 1'b0, s);
  endtask

  task automatic check_sb(input string tag);
    check({tag, "_we_count"}, got_we_q.size(), exp_we_q.size());
    while (exp_we_q.size() > 0 && got_we_q.size() > 0)
      check({tag, "_we_addr_data"}, got_we_q.pop_front(), exp_we_q.pop_front());
    check({tag, "_re_count"}, got_re_q.size(), exp_re_q.size());
    while (exp_re_q.size() > 0 && got_re_q.size() > 0)
      check({tag, "_re_addr"}, got_re_q.pop_front(), exp_re_q.pop_front());
    exp_we_q.delete(); got_we_q.delete(); exp_re_q.delete(); got_re_q.delete();
    check({tag, "_reg_addr"}, reg_addr, m_ptr);
  endtask

  // Pointer write followed by the bytes in wr_data_q.
  task automatic xfer_write(input string tag, input logic [7:0] ptr);
    logic ack;
    bus_start();
    write_byte(8'hA0, -1, ack); check({tag, "_addr_ack"}, ack, 1);
    check({tag, "_busy_active"}, busy, 1);
    write_byte(ptr, -1, ack);   check({tag, "_ptr_ack"}, ack, 1);
    m_ptr = ptr;
    while (wr_data_q.size() > 0) begin
      logic [7:0] d;
      d = wr_data_q.pop_front();
      write_byte(d, -1, ack);   check({tag, "_data_ack"}, ack, 1);
      exp_we_q.push_back({m_ptr, d});
      m_ptr = m_ptr + 8'd1;
    end
    bus_stop();
    check({tag, "_busy_after_stop"}, busy, 0);
    check_sb(tag);
  endtask

  // Pointer write, repeated START, then n reads (last one NACKed).
  task automatic xfer_read(input string tag, input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] d;
    bus_start();
    write_byte(8'hA0, -1, ack); check({tag, "_waddr_ack"}, ack, 1);
    write_byte(ptr, -1, ack);   check({tag, "_ptr_ack"}, ack, 1);
    m_ptr = ptr;
    bus_start();
    write_byte(8'hA1, -1, ack); check({tag, "_raddr_ack"}, ack, 1);
    for (int k = 0; k < n; k++) begin
      exp_re_q.push_back(m_ptr);
      read_byte(k == n - 1, d);
      m_ptr = m_ptr + 8'd1;
      if (sent_q.size() > 0) check({tag, "_rd_data"}, d, sent_q.pop_front());
      else check({tag, "_rd_request_seen"}, 0, 1);
    end
    wait_clk(2);
    check({tag, "_busy_after_nack"}, busy, 0);
    check({tag, "_sda_released"}, sda_oe, 0);
    bus_stop();
    sent_q.delete();
    check_sb(tag);
  endtask

  task automatic xfer_wrong_addr(input string tag, input logic [7:0] abyte);
    logic ack;
    int oe0;
    oe0 = oe_cycles;
    bus_start();
    write_byte(abyte, -1, ack);
    check({tag, "_no_ack"}, ack, 0);
    check({tag, "_busy_idle"}, busy, 0);
    bus_stop();
    check({tag, "_sda_never_low"}, oe_cycles - oe0, 0);
    check_sb(tag);
  endtask

  initial begin
    logic ack, s;
    logic b_q[$];
    logic [7:0] glitch_exp;

    // Reset values
    wait_clk(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_re", reg_re, 0);
    check("rst_busy", busy, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    reset = 1'b0;
    wait_clk(8);

    // Test 1: pointer 0x10, data 0x5A, 0x3C
    wr_data_q = '{8'h5A, 8'h3C};
    xfer_write("t1", 8'h10);

    // Test 2: wrong address 0x51 (write)
    xfer_wrong_addr("t2", 8'hA2);

    // Test 3: pointer 0x20, read 0x81 (ACK), 0x7E (NACK)
    core_q = '{8'h81, 8'h7E};
    xfer_read("t3", 8'h20, 2);

    // Test 4: pointer wrap 0xFF -> 0x00
    wr_data_q = '{8'h11, 8'h22};
    xfer_write("t4", 8'hFF);

    // Test 5: reset while the ACK is being driven
    bus_start();
    for (int i = 0; i < 8; i++) clk_bit(((8'hA0 >> (7 - i)) & 8'h01) != 0, 1'b0, s);
    wait_clk(8);
    check("t5_ack_driven", sda_oe, 1);
    reset = 1'b1;
    #1;
    check("t5_sda_released_in_reset", sda_oe, 0);
    check("t5_busy_in_reset", busy, 0);
    scl = 1'b1; sda_m = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    m_ptr = 8'h00;
    wait_clk(8);
    check("t5_reg_addr_after_reset", reg_addr, 0);
    wr_data_q = '{8'h5A, 8'h3C};
    xfer_write("t5_t1", 8'h10);

    // Test 6: one-cycle SCL low glitch on bit 2 of data byte 0x5A
    b_q.delete();
    for (int i = 0; i < 8; i++) begin
      b_q.push_back(((8'h5A >> (7 - i)) & 8'h01) != 0);
      if (i == 2) b_q.push_back(((8'h5A >> (7 - i)) & 8'h01) != 0);
    end
    glitch_exp = 8'h00;
    for (int i = 0; i < 8; i++) glitch_exp = {glitch_exp[6:0], b_q[i]};
`ifdef I2C_GLITCH_FILTER_EN
    glitch_exp = 8'h5A;
`endif
    bus_start();
    write_byte(8'hA0, -1, ack); check("t6_addr_ack", ack, 1);
    write_byte(8'h30, -1, ack); check("t6_ptr_ack", ack, 1);
    write_byte(8'h5A, 2, ack);
    bus_stop();
    exp_we_q.push_back({8'h30, glitch_exp});
    m_ptr = 8'h31;
    check_sb("t6");

    // Randomized transactions
    for (int it = 0; it < 8; it++) begin
      int kind;
      logic [7:0] ptr;
      kind = $urandom_range(0, 2);
      ptr  = 8'($urandom);
      if (kind == 0) begin
        wr_data_q.delete();
        repeat ($urandom_range(1, 3)) wr_data_q.push_back(8'($urandom));
        xfer_write("rnd_wr", ptr);
      end else if (kind == 1) begin
        xfer_read("rnd_rd", ptr, $urandom_range(1, 3));
      end else begin
        logic [6:0] a7;
        a7 = 7'($urandom_range(0, 127));
        if (a7 == 7'h50) a7 = 7'h51;
        xfer_wrong_addr("rnd_bad", {a7, 1'($urandom)});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
